// File: rtl/bmd_axist_cq_1024_to_512_gearbox.sv
// CQ AXI-ST gearbox: splits each 1024b completer-request beat into one or two 512b beats with backpressure.
// Optional build macro BMD_GEARBOX_PARITY_EN carries parity per half and adds a sticky par_err output.
module bmd_axist_cq_1024_to_512_gearbox #(
    parameter int HOLD_DEPTH      = 2,
    parameter bit DROP_EMPTY_HIGH = 1'b1
) (
    input  logic          user_clk,
    input  logic          reset,
    input  logic [1023:0] s_tdata,
    input  logic [31:0]   s_tkeep,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_is_sop,
    input  logic [4:0]    s_eop_ptr,
    input  logic [127:0]  s_byte_en,
    input  logic          s_discontinue,
    input  logic [127:0]  s_parity,
    output logic [511:0]  m_tdata,
    output logic [15:0]   m_tkeep,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_is_sop,
    output logic          m_is_eop,
    output logic [3:0]    m_eop_ptr,
    output logic [63:0]   m_byte_en,
    output logic          m_discontinue,
    output logic [63:0]   m_parity,
    output logic          err_straddle
`ifdef BMD_GEARBOX_PARITY_EN
    ,
    output logic          par_err
`endif
);

    localparam int             PW       = 1;
    localparam logic [PW-1:0]  LAST_PTR = PW'(HOLD_DEPTH - 1);
    localparam logic [1:0]     DEPTH_C  = 2'(HOLD_DEPTH);

    typedef struct packed {
        logic [1023:0] data;
        logic [31:0]   keep;
        logic          last;
        logic          sop;
        logic [4:0]    eop;
        logic [127:0]  be;
        logic          disc;
`ifdef BMD_GEARBOX_PARITY_EN
        logic [127:0]  par;
`endif
    } entry_t;

    entry_t          mem [HOLD_DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [1:0]      count;
    logic            half_hi;
    logic            in_tlp;
    logic            empty;
    logic            full;
    logic            skip_high;
    logic            final_half;
    logic            out_hs;
    logic            pop;
    logic            push;

    assign empty  = (count == 2'd0);
    assign full   = (count == DEPTH_C);
    assign head   = mem[rd_ptr];

    // The upper half is redundant when the TLP ends inside the lower 16 dwords or carries no upper dwords.
    assign skip_high  = (head.last && !head.eop[4]) ||
                        (DROP_EMPTY_HIGH && (head.keep[31:16] == 16'h0000));
    assign final_half = half_hi || skip_high;
    assign out_hs     = m_tvalid && m_tready;
    assign pop        = out_hs && final_half;

    // Combinational ready lets a full buffer accept while its head leaves, so there is no bubble.
    assign s_tready = !reset && (!full || pop);
    assign push     = s_tvalid && s_tready;

    always_comb begin
        in_entry      = '0;
        in_entry.data = s_tdata;
        in_entry.keep = s_tkeep;
        in_entry.last = s_tlast;
        in_entry.sop  = s_is_sop;
        in_entry.eop  = s_eop_ptr;
        in_entry.be   = s_byte_en;
        in_entry.disc = s_discontinue;
`ifdef BMD_GEARBOX_PARITY_EN
        in_entry.par  = s_parity;
`endif
    end

    // NOTE: the payload array has no reset; validity is carried entirely by count, which is reset.
    always_ff @(posedge user_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 2'd0;
            half_hi <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (out_hs) begin
                half_hi <= !final_half;
            end
        end
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            in_tlp       <= 1'b0;
            err_straddle <= 1'b0;
        end else if (push) begin
            if (s_is_sop && in_tlp) begin
                err_straddle <= 1'b1;
            end
            if (s_tlast) begin
                in_tlp <= 1'b0;
            end else if (s_is_sop) begin
                in_tlp <= 1'b1;
            end
        end
    end

`ifdef BMD_GEARBOX_PARITY_EN
    logic [127:0] par_exp;

    always_comb begin
        par_exp = '0;
        for (int i = 0; i < 128; i++) begin
            par_exp[i] = ~^s_tdata[8*i +: 8];
        end
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            par_err <= 1'b0;
        end else if (push && (s_parity != par_exp)) begin
            par_err <= 1'b1;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^s_parity;
`endif

    // NOTE: every output gets a default first so the mux cannot infer a latch.
    always_comb begin
        m_tvalid      = 1'b0;
        m_tdata       = '0;
        m_tkeep       = '0;
        m_byte_en     = '0;
        m_parity      = '0;
        m_is_sop      = 1'b0;
        m_tlast       = 1'b0;
        m_eop_ptr     = '0;
        m_discontinue = 1'b0;
        if (!empty) begin
            m_tvalid = 1'b1;
            if (half_hi) begin
                m_tdata   = head.data[1023:512];
                m_tkeep   = head.keep[31:16];
                m_byte_en = head.be[127:64];
`ifdef BMD_GEARBOX_PARITY_EN
                m_parity  = head.par[127:64];
`endif
            end else begin
                m_tdata   = head.data[511:0];
                m_tkeep   = head.keep[15:0];
                m_byte_en = head.be[63:0];
`ifdef BMD_GEARBOX_PARITY_EN
                m_parity  = head.par[63:0];
`endif
            end
            m_is_sop      = head.sop && !half_hi;
            m_tlast       = head.last && final_half;
            m_eop_ptr     = final_half ? head.eop[3:0] : 4'h0;
            m_discontinue = head.disc && final_half;
        end
    end

    assign m_is_eop = m_tlast;

endmodule

// File: tb/tb_bmd_axist_cq_1024_to_512_gearbox.sv
// Directed bench for the CQ 1024->512 gearbox: a queue model of expected 512b beats plus literal spot checks.
module tb_bmd_axist_cq_1024_to_512_gearbox;

    localparam int HOLD_DEPTH      = 2;
    localparam bit DROP_EMPTY_HIGH = 1'b1;

    typedef struct packed {
        logic [1023:0] data;
        logic [31:0]   keep;
        logic          last;
        logic          sop;
        logic [4:0]    eop;
        logic [127:0]  be;
        logic          disc;
        logic [127:0]  par;
    } in_t;

    typedef struct packed {
        logic [511:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         sop;
        logic [3:0]   eop;
        logic [63:0]  be;
        logic         disc;
        logic [63:0]  par;
    } out_t;

    logic          user_clk = 1'b0;
    logic          reset    = 1'b1;
    logic [1023:0] s_tdata  = '0;
    logic [31:0]   s_tkeep  = '0;
    logic          s_tlast  = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_is_sop = 1'b0;
    logic [4:0]    s_eop_ptr = '0;
    logic [127:0]  s_byte_en = '0;
    logic          s_discontinue = 1'b0;
    logic [127:0]  s_parity = '0;
    logic [511:0]  m_tdata;
    logic [15:0]   m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_is_sop;
    logic          m_is_eop;
    logic [3:0]    m_eop_ptr;
    logic [63:0]   m_byte_en;
    logic          m_discontinue;
    logic [63:0]   m_parity;
    logic          err_straddle;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];

    bmd_axist_cq_1024_to_512_gearbox #(
        .HOLD_DEPTH      (HOLD_DEPTH),
        .DROP_EMPTY_HIGH (DROP_EMPTY_HIGH)
    ) dut (
        .user_clk      (user_clk),
        .reset         (reset),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_is_sop      (s_is_sop),
        .s_eop_ptr     (s_eop_ptr),
        .s_byte_en     (s_byte_en),
        .s_discontinue (s_discontinue),
        .s_parity      (s_parity),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_is_sop      (m_is_sop),
        .m_is_eop      (m_is_eop),
        .m_eop_ptr     (m_eop_ptr),
        .m_byte_en     (m_byte_en),
        .m_discontinue (m_discontinue),
        .m_parity      (m_parity),
        .err_straddle  (err_straddle)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic in_t mk(input logic [31:0] keep, input logic sop, input logic last,
                               input logic [4:0] eop, input logic disc);
        in_t b;
        for (int i = 0; i < 32; i++) begin
            b.data[32*i +: 32] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            b.be[32*i +: 32]  = $urandom;
            b.par[32*i +: 32] = $urandom;
        end
        b.keep = keep;
        b.sop  = sop;
        b.last = last;
        b.eop  = eop;
        b.disc = disc;
        return b;
    endfunction

    // Expected 512b beats for one accepted 1024b beat, straight from the splitting rules.
    function automatic void model_push(input in_t b);
        out_t lo;
        out_t hi;
        bit   ends_low;
        bit   use_high;
        ends_low = b.last && (b.eop < 5'd16);
        use_high = !ends_low && (!DROP_EMPTY_HIGH || (b.keep[31:16] != 16'h0));
        lo.data = b.data[511:0];
        lo.keep = b.keep[15:0];
        lo.be   = b.be[63:0];
        lo.sop  = b.sop;
        lo.last = b.last && !use_high;
        lo.eop  = use_high ? 4'h0 : b.eop[3:0];
        lo.disc = b.disc && !use_high;
`ifdef BMD_GEARBOX_PARITY_EN
        lo.par  = b.par[63:0];
`else
        lo.par  = '0;
`endif
        exp_q.push_back(lo);
        if (use_high) begin
            hi.data = b.data[1023:512];
            hi.keep = b.keep[31:16];
            hi.be   = b.be[127:64];
            hi.sop  = 1'b0;
            hi.last = b.last;
            hi.eop  = b.eop[3:0];
            hi.disc = b.disc;
`ifdef BMD_GEARBOX_PARITY_EN
            hi.par  = b.par[127:64];
`else
            hi.par  = '0;
`endif
            exp_q.push_back(hi);
        end
    endfunction

    // Every valid output cycle is compared with the head of the model queue; it pops on handshake.
    always @(negedge user_clk) begin
        if (!reset && m_tvalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got keep=%h sop=%0b last=%0b, want no beat", m_tkeep, m_is_sop, m_tlast);
            end else begin
                if (m_tdata !== exp_q[0].data || m_tkeep !== exp_q[0].keep || m_tlast !== exp_q[0].last ||
                    m_is_sop !== exp_q[0].sop || m_eop_ptr !== exp_q[0].eop || m_byte_en !== exp_q[0].be ||
                    m_discontinue !== exp_q[0].disc || m_parity !== exp_q[0].par || m_is_eop !== exp_q[0].last) begin
                    n_bad++;
                    $display("FAIL beat: got keep=%h last=%0b eop_flag=%0b sop=%0b eop=%h be=%h disc=%0b data_ok=%0b par_ok=%0b, want keep=%h last=%0b sop=%0b eop=%h be=%h disc=%0b",
                             m_tkeep, m_tlast, m_is_eop, m_is_sop, m_eop_ptr, m_byte_en, m_discontinue,
                             m_tdata === exp_q[0].data, m_parity === exp_q[0].par,
                             exp_q[0].keep, exp_q[0].last, exp_q[0].sop, exp_q[0].eop, exp_q[0].be, exp_q[0].disc);
                end
                if (m_tready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input in_t b);
        int waited = 0;
        s_tdata       = b.data;
        s_tkeep       = b.keep;
        s_tlast       = b.last;
        s_is_sop      = b.sop;
        s_eop_ptr     = b.eop;
        s_byte_en     = b.be;
        s_discontinue = b.disc;
        s_parity      = b.par;
        s_tvalid      = 1'b1;
        while (!s_tready && waited < 100) begin
            @(negedge user_clk);
            waited++;
        end
        if (!s_tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got s_tready=0 for %0d cycles, want acceptance", waited);
        end else begin
            @(posedge user_clk);
            model_push(b);
            #1;
        end
        s_tvalid      = 1'b0;
        s_is_sop      = 1'b0;
        s_tlast       = 1'b0;
        s_discontinue = 1'b0;
        s_eop_ptr     = '0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || m_tvalid) && waited < 200) begin
            @(negedge user_clk);
            waited++;
        end
        if (exp_q.size() != 0 || m_tvalid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d beats outstanding, want 0", exp_q.size());
        end
    endtask

    in_t a_beat;
    in_t b_beat;
    in_t c_beat;

    initial begin
        // Reset state
        repeat (2) @(negedge user_clk);
        check("reset_tvalid", 64'(m_tvalid), 64'd0);
        check("reset_tready", 64'(s_tready), 64'd0);
        check("reset_tkeep", 64'(m_tkeep), 64'd0);
        check("reset_err", 64'(err_straddle), 64'd0);
        reset = 1'b0;
        @(posedge user_clk);
        #1 m_tready = 1'b1;

        // Single-beat MRd followed immediately by a 24-dword MWr
        send(mk(32'h0000000F, 1'b1, 1'b1, 5'd3, 1'b0));
        @(negedge user_clk);
        check("mrd_keep", 64'(m_tkeep), 64'h000F);
        check("mrd_sop", 64'(m_is_sop), 64'd1);
        check("mrd_last", 64'(m_tlast), 64'd1);
        check("mrd_eop", 64'(m_eop_ptr), 64'd3);
        check("mrd_next_ready", 64'(s_tready), 64'd1);
        send(mk(32'h00FFFFFF, 1'b1, 1'b1, 5'd23, 1'b0));
        check("mwr_b1_keep", 64'(m_tkeep), 64'hFFFF);
        check("mwr_b1_sop", 64'(m_is_sop), 64'd1);
        check("mwr_b1_last", 64'(m_tlast), 64'd0);
        @(posedge user_clk);
        #1;
        check("mwr_b2_keep", 64'(m_tkeep), 64'h00FF);
        check("mwr_b2_last", 64'(m_tlast), 64'd1);
        check("mwr_b2_eop", 64'(m_eop_ptr), 64'd7);
        check("mwr_b2_sop", 64'(m_is_sop), 64'd0);
        drain();

        // Backpressure while the HIGH half is presented
        a_beat = mk(32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 1'b0);
        b_beat = mk(32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 1'b0);
        c_beat = mk(32'hFFFFFFFF, 1'b0, 1'b1, 5'd31, 1'b0);
        send(a_beat);
        @(posedge user_clk);
        #1 m_tready = 1'b0;
        send(b_beat);
        fork
            send(c_beat);
            begin
                repeat (5) begin
                    @(negedge user_clk);
                    check("stall_data_hi", 64'(m_tdata !== a_beat.data[1023:512]), 64'd0);
                    check("stall_keep", 64'(m_tkeep), 64'hFFFF);
                    check("stall_tready", 64'(s_tready), 64'd0);
                end
                @(posedge user_clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();

        // Three full beats back to back: six contiguous output beats
        fork
            begin
                send(mk(32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 1'b0));
                send(mk(32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 1'b0));
                send(mk(32'hFFFFFFFF, 1'b0, 1'b1, 5'd31, 1'b0));
            end
            begin
                int w = 0;
                @(negedge user_clk);
                while (!m_tvalid && w < 20) begin
                    @(negedge user_clk);
                    w++;
                end
                for (int k = 0; k < 6; k++) begin
                    check("b2b_valid", 64'(m_tvalid), 64'd1);
                    check("b2b_sop", 64'(m_is_sop), 64'(k == 0));
                    check("b2b_last", 64'(m_tlast), 64'(k == 5));
                    if (k == 5) check("b2b_eop", 64'(m_eop_ptr), 64'd15);
                    if (k < 5) @(negedge user_clk);
                end
            end
        join
        drain();

        // Empty upper half skipped, then a discontinued TLP ending in the upper half
        send(mk(32'h0000FFFF, 1'b1, 1'b0, 5'd0, 1'b0));
        send(mk(32'hFFFFFFFF, 1'b0, 1'b1, 5'd20, 1'b1));
        drain();

        // Straddle violation
        send(mk(32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 1'b0));
        @(negedge user_clk);
        check("straddle_before", 64'(err_straddle), 64'd0);
        send(mk(32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 1'b0));
        @(negedge user_clk);
        check("straddle_set", 64'(err_straddle), 64'd1);
        drain();
        send(mk(32'h0000000F, 1'b1, 1'b1, 5'd3, 1'b0));
        drain();
        check("straddle_sticky", 64'(err_straddle), 64'd1);

        // Asynchronous reset mid-TLP
        @(posedge user_clk);
        #1 m_tready = 1'b0;
        send(mk(32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 1'b0));
        @(negedge user_clk);
        check("pre_reset_valid", 64'(m_tvalid), 64'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_valid", 64'(m_tvalid), 64'd0);
        check("async_reset_tready", 64'(s_tready), 64'd0);
        check("async_reset_err", 64'(err_straddle), 64'd0);
        check("async_reset_keep", 64'(m_tkeep), 64'd0);
        @(negedge user_clk);
        reset = 1'b0;
        @(posedge user_clk);
        #1 m_tready = 1'b1;
        send(mk(32'h000000FF, 1'b1, 1'b1, 5'd7, 1'b0));
        @(negedge user_clk);
        check("post_reset_valid", 64'(m_tvalid), 64'd1);
        check("post_reset_sop", 64'(m_is_sop), 64'd1);
        drain();
        check("model_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
